aes_ram_arbiter: RTL and testbench
==================================

# aes_ram_arbiter

Round-robin arbiter that shares one port of the AES dual-port state/key RAM among up to `NUM_REQ` requesters, such as the key expander, round datapath and host loader. Each cycle it grants at most one request, drives the RAM port, and returns read data one cycle later with a per-requester valid. A lock input lets one requester hold the port for a multi-byte burst, for example a 16-byte state load.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `ADDR_WIDTH`, 4, RAM address width
- `DATA_WIDTH`, 8, RAM data width
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  NUM_REQ  access request per requester; held until granted
- `lock`  in  NUM_REQ  keep ownership after this access
- `we`  in  NUM_REQ  1 = write, 0 = read
- `addr`  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- `wdata`  in  NUM_REQ*DATA_WIDTH  flattened write data, same slicing rule
- `gnt`  out  NUM_REQ  one-hot (or zero) grant; combinational; the access is performed this cycle
- `rvalid`  out  NUM_REQ  registered; pulses one cycle after a granted read
- `rdata`  out  DATA_WIDTH  read data, shared by all requesters; qualified by `rvalid`
- `ram_addr`  out  ADDR_WIDTH  to RAM port address
- `ram_wr_ena`  out  1  to RAM port write enable
- `ram_in`  out  DATA_WIDTH  to RAM port write data
- `ram_out`  in  DATA_WIDTH  from RAM port registered read data

## Operation
- State: priority pointer `ptr` (0..NUM_REQ-1); FSM {IDLE, LOCKED}; lock owner `own`; pending-read register `rd_pend` (NUM_REQ bits).
- IDLE: the winner is the first i with `req[i]`, scanning from `ptr` upward with wrap-around. `gnt[i]=1`. RAM port driven from slice i, and `ram_wr_ena = we[i]`.
  - If `lock[i]=0`: `ptr <= (i+1) mod NUM_REQ`.
  - If `lock[i]=1`: FSM moves to LOCKED, `own <= i`, and `ptr` is unchanged.
- LOCKED: only `own` is eligible; all other requests see `gnt=0`.
  - `req[own]=1, lock[own]=1`: granted, and the FSM stays LOCKED.
  - `req[own]=1, lock[own]=0`: granted; this is the last access. Next state IDLE, `ptr <= own+1`.
  - `req[own]=0`: no grant, and the FSM returns to IDLE with `ptr <= own+1`. This is an idle release.
- No request: `gnt=0`, `ram_wr_ena=0`. `ram_addr` and `ram_in` hold the slice-0 value (don't-care), and `ptr` is unchanged.
- Writes produce no `rvalid`. Reads set `rd_pend[i]` for one cycle. `rvalid <= rd_pend`, and `rdata` passes `ram_out` through.
- `lock` is ignored for requesters that are not granted.

## Timing
- Grant latency: 0 cycles. `gnt` is asserted in the same cycle as `req` if the requester wins.
- Read latency: `rvalid[i]` and valid `rdata` appear exactly 1 cycle after the granted cycle (the RAM output register).
- Back-to-back accesses are allowed. The sustained rate is one access per cycle, and `rvalid` can be high on consecutive cycles for different requesters.
- Read after write, same address, consecutive cycles: the read returns the new data. A read in the same cycle as a write through the other RAM port returns the old data; this is the RAM's read-before-write behaviour and is not arbitrated here.
- Reset (asynchronous assert): `ptr=0`, FSM=IDLE, `rd_pend=0`, `rvalid=0`.
  - While `rst_n=0`, `gnt=0` and `ram_wr_ena=0`, with combinational masking.
  - A read granted in the cycle before reset produces no `rvalid`.
- Reset deassertion mid-burst: the lock is lost and requesters restart their bursts.

## Structure
- Shared package `aes_pkg`: `NUM_REQ` default, the FSM state enum {IDLE, LOCKED}, and the requester index constants (KEYEXP=0, ROUND=1, HOST=2, SPARE=3).
- One sub-module: `rr_pick`. It is a combinational round-robin priority picker: inputs are the request vector and `ptr`; outputs are a one-hot grant and a winner index. The top level holds the FSM, pointer, mux and read pipeline.

## Test plan
- Reset: hold `rst_n=0` with `req=4'b1111` -> `gnt=0`, `rvalid=0`, `ram_wr_ena=0`. After release, first cycle -> `gnt=4'b0001`.
- Round-robin: `req=4'b1111` held for 8 cycles, all reads, no lock -> grant order 0,1,2,3,0,1,2,3. Each `rvalid[i]` appears one cycle after `gnt[i]`.
- Write then read: requester 2 writes 8'hA5 to address 4'h7, then reads address 4'h7 -> in the cycle after the read grant, `rvalid=4'b0100` and `rdata=8'hA5`.
- Lock burst: requester 1 does 16 locked writes (addresses 0..15, lock dropped on the last) while `req[0]` and `req[3]` are held -> only `gnt[1]` for 16 cycles, then `gnt[3]` and then `gnt[0]`, since `ptr=2`.
- Idle release: requester 0 locks, then deasserts `req` -> the next cycle, requester 3 (pending) is granted and `ptr` becomes 1.
- Async reset mid-read: assert `rst_n` low between a read grant and its return -> `rvalid` stays 0, and `ptr=0` after release.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES RAM port arbiter.
package aes_pkg;

  localparam int unsigned NUM_REQ_DEFAULT = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned KEYEXP = 0;
  localparam int unsigned ROUND  = 1;
  localparam int unsigned HOST   = 2;
  localparam int unsigned SPARE  = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request scanning upward
// from ptr_i with wrap-around.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW-1:0] j;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_o = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IW'((32'(ptr_i) + k) % N);
      if (!found_o && req_i[j]) begin
        found_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/aes_ram_arbiter.sv
// Round-robin arbiter sharing one AES state/key RAM port among NUM_REQ
// requesters, with lock-based bursts and a one-cycle read-valid pipeline.
module aes_ram_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic                          ram_wr_ena,
  output logic [DATA_WIDTH-1:0]         ram_in,
  input  logic [DATA_WIDTH-1:0]         ram_out
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       own_q, own_d;
  logic [NUM_REQ-1:0]  rd_pend_q, rd_pend_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_found;
  logic [IW-1:0]       win;
  logic                grant_any;

  function automatic logic [IW-1:0] inc_ptr(input logic [IW-1:0] p);
    return (32'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    gnt       = '0;
    win       = '0;
    grant_any = 1'b0;
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    if (state_q == IDLE) begin
      if (pick_found) begin
        gnt       = pick_gnt;
        win       = pick_idx;
        grant_any = 1'b1;
        if (lock[pick_idx]) begin
          state_d = LOCKED;
          own_d   = pick_idx;
        end else begin
          ptr_d = inc_ptr(pick_idx);
        end
      end
    end else begin
      if (req[own_q]) begin
        gnt[own_q] = 1'b1;
        win        = own_q;
        grant_any  = 1'b1;
      end
      // Covers both the final locked access and an idle release.
      if (!(req[own_q] && lock[own_q])) begin
        state_d = IDLE;
        ptr_d   = inc_ptr(own_q);
      end
    end
    if (!rst_n) begin
      gnt       = '0;
      grant_any = 1'b0;
    end
    rd_pend_d = gnt & ~we;
  end

  assign ram_addr   = addr[32'(win)*ADDR_WIDTH +: ADDR_WIDTH];
  assign ram_in     = wdata[32'(win)*DATA_WIDTH +: DATA_WIDTH];
  assign ram_wr_ena = grant_any & we[win];
  assign rvalid     = rd_pend_q;
  assign rdata      = ram_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      own_q     <= '0;
      rd_pend_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      rd_pend_q <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_aes_ram_arbiter.sv
// Directed self-checking bench for aes_ram_arbiter with a behavioural
// registered-output RAM on the arbitrated port.
module tb_aes_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, lock, we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt, rvalid;
  logic [7:0]  rdata;
  logic [3:0]  ram_addr;
  logic        ram_wr_ena;
  logic [7:0]  ram_in;
  logic [7:0]  ram_out;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [16];
  logic [15:0] written = '0;

  aes_ram_arbiter #(
    .NUM_REQ    (4),
    .ADDR_WIDTH (4),
    .DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .lock       (lock),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .ram_addr   (ram_addr),
    .ram_wr_ena (ram_wr_ena),
    .ram_in     (ram_in),
    .ram_out    (ram_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten locations read back as 8'h30 + address.
  always @(posedge clk) begin
    if (ram_wr_ena) begin
      mem[ram_addr]     <= ram_in;
      written[ram_addr] <= 1'b1;
    end
    ram_out <= written[ram_addr] ? mem[ram_addr] : (8'h30 + 8'(ram_addr));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive(input int i, input logic r, input logic l, input logic w,
                       input logic [3:0] a, input logic [7:0] d);
    req[i] = r; lock[i] = l; we[i] = w;
    addr[i*4 +: 4]  = a;
    wdata[i*8 +: 8] = d;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    req = 4'b1111; we = 4'b1111;
    #2;
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    tests++; if (rvalid !== 4'b0000) begin fails++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid); end
    tests++; if (ram_wr_ena !== 1'b0) begin fails++; $display("FAIL reset_wr_ena got=%b exp=0", ram_wr_ena); end
    step();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt_hold got=%b exp=0000", gnt); end
    tests++; if (ram_wr_ena !== 1'b0) begin fails++; $display("FAIL reset_wr_hold got=%b exp=0", ram_wr_ena); end
    rst_n = 1'b1; we = 4'b0000;
    #1;
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
    step();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g, exp_v;
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 1'b0, 1'b0, 4'(8 + i), 8'h00);
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_g = 4'b0001 << (c % 4);
      tests++; if (gnt !== exp_g) begin fails++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, exp_g); end
      if (c > 0) begin
        exp_v = 4'b0001 << ((c - 1) % 4);
        exp_d = 8'h38 + 8'((c - 1) % 4);
        tests++; if (rvalid !== exp_v) begin fails++; $display("FAIL rr_rvalid c=%0d got=%b exp=%b", c, rvalid, exp_v); end
        tests++; if (rdata !== exp_d) begin fails++; $display("FAIL rr_rdata c=%0d got=%h exp=%h", c, rdata, exp_d); end
      end else begin
        tests++; if (rvalid !== 4'b0000) begin fails++; $display("FAIL rr_rvalid0 got=%b exp=0000", rvalid); end
      end
      step();
    end
    clear_inputs();
    #1;
    tests++; if (rvalid !== 4'b1000) begin fails++; $display("FAIL rr_rvalid_last got=%b exp=1000", rvalid); end
    tests++; if (rdata !== 8'h3B) begin fails++; $display("FAIL rr_rdata_last got=%h exp=3b", rdata); end
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL rr_gnt_none got=%b exp=0000", gnt); end
    step();
  endtask

  task automatic test_write_read();
    do_reset();
    drive(2, 1'b1, 1'b0, 1'b1, 4'h7, 8'hA5);
    #1;
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL wr_gnt got=%b exp=0100", gnt); end
    tests++; if (ram_wr_ena !== 1'b1) begin fails++; $display("FAIL wr_ena got=%b exp=1", ram_wr_ena); end
    tests++; if (ram_addr !== 4'h7) begin fails++; $display("FAIL wr_addr got=%h exp=7", ram_addr); end
    tests++; if (ram_in !== 8'hA5) begin fails++; $display("FAIL wr_data got=%h exp=a5", ram_in); end
    step();
    drive(2, 1'b1, 1'b0, 1'b0, 4'h7, 8'h00);
    #1;
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL rd_gnt got=%b exp=0100", gnt); end
    tests++; if (ram_wr_ena !== 1'b0) begin fails++; $display("FAIL rd_wr_ena got=%b exp=0", ram_wr_ena); end
    tests++; if (rvalid !== 4'b0000) begin fails++; $display("FAIL wr_no_rvalid got=%b exp=0000", rvalid); end
    step();
    clear_inputs();
    #1;
    tests++; if (rvalid !== 4'b0100) begin fails++; $display("FAIL raw_rvalid got=%b exp=0100", rvalid); end
    tests++; if (rdata !== 8'hA5) begin fails++; $display("FAIL raw_rdata got=%h exp=a5", rdata); end
    step();
  endtask

  task automatic test_lock_burst();
    do_reset();
    drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL lk_pre_gnt got=%b exp=0001", gnt); end
    step();
    drive(3, 1'b1, 1'b0, 1'b0, 4'h3, 8'h00);
    for (int k = 0; k < 16; k++) begin
      drive(1, 1'b1, (k != 15), 1'b1, 4'(k), 8'(k) ^ 8'h5A);
      #1;
      tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL lk_gnt k=%0d got=%b exp=0010", k, gnt); end
      tests++; if (ram_addr !== 4'(k)) begin fails++; $display("FAIL lk_addr k=%0d got=%h exp=%h", k, ram_addr, 4'(k)); end
      tests++; if (ram_wr_ena !== 1'b1) begin fails++; $display("FAIL lk_wr k=%0d got=%b exp=1", k, ram_wr_ena); end
      step();
    end
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL lk_after3 got=%b exp=1000", gnt); end
    step();
    drive(3, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL lk_after0 got=%b exp=0001", gnt); end
    step();
    clear_inputs();
    drive(2, 1'b1, 1'b0, 1'b0, 4'h5, 8'h00);
    #1;
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL lk_rb_gnt got=%b exp=0100", gnt); end
    step();
    clear_inputs();
    #1;
    tests++; if (rvalid !== 4'b0100) begin fails++; $display("FAIL lk_rb_rvalid got=%b exp=0100", rvalid); end
    tests++; if (rdata !== 8'h5F) begin fails++; $display("FAIL lk_rb_rdata got=%h exp=5f", rdata); end
    step();
  endtask

  task automatic test_idle_release();
    do_reset();
    drive(0, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00);
    drive(3, 1'b1, 1'b0, 1'b0, 4'h3, 8'h00);
    #1;
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL ir_lock_gnt got=%b exp=0001", gnt); end
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    #1;
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL ir_release_gnt got=%b exp=0000", gnt); end
    step();
    #1;
    tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL ir_pending_gnt got=%b exp=1000", gnt); end
    step();
    clear_inputs();
    drive(0, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00);
    #1;
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL ir2_lock_gnt got=%b exp=0001", gnt); end
    step();
    clear_inputs();
    #1;
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL ir2_release_gnt got=%b exp=0000", gnt); end
    step();
    drive(0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 4'h1, 8'h00);
    #1;
    tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL ir2_ptr_gnt got=%b exp=0010", gnt); end
    step();
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 1'b1, 1'b0, 1'b0, 4'h1, 8'h00);
    #1;
    tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL ar_gnt1 got=%b exp=0010", gnt); end
    step();
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(2, 1'b1, 1'b0, 1'b0, 4'h2, 8'h00);
    #1;
    tests++; if (rvalid !== 4'b0010) begin fails++; $display("FAIL ar_rvalid1 got=%b exp=0010", rvalid); end
    tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL ar_gnt2 got=%b exp=0100", gnt); end
    step();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    tests++; if (rvalid !== 4'b0000) begin fails++; $display("FAIL ar_rvalid_killed got=%b exp=0000", rvalid); end
    step();
    tests++; if (rvalid !== 4'b0000) begin fails++; $display("FAIL ar_rvalid_hold got=%b exp=0000", rvalid); end
    rst_n = 1'b1;
    req = 4'b1111;
    #1;
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL ar_ptr_reset got=%b exp=0001", gnt); end
    step();
    clear_inputs();
    #1;
    tests++; if (rvalid !== 4'b0001) begin fails++; $display("FAIL ar_rvalid_after got=%b exp=0001", rvalid); end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_round_robin();
    test_write_read();
    test_lock_burst();
    test_idle_release();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
